// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter sharing one UART baud generator and Tx serializer among NUM_REQ requesters
module uart_tx_sched #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 200000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [2*NUM_REQ-1:0]       req_baud,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic [1:0]                 baud_rate,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2((TIMEOUT > GAP_CYCLES ? TIMEOUT : GAP_CYCLES) + 1);
    localparam logic [2:0] IDLE = 3'd0, CFG = 3'd1, START = 3'd2, WAIT = 3'd3, GAP = 3'd4;

    logic [2:0]    state;
    logic [IW-1:0] last, win, cand;
    logic [CW-1:0] cnt;
    logic [1:0]    w_baud;

    always_comb begin
        win  = last;
        cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % NUM_REQ);
            win  = req[cand] ? cand : win;
        end
    end

    assign w_baud = req_baud[{win, 1'b0} +: 2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ack         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'd0;
            baud_rate   <= 2'd0;
            busy        <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            last        <= IW'(NUM_REQ - 1);
            cnt         <= '0;
        end else begin
            ack         <= '0;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: if (|req) begin
                    ack[win]  <= 1'b1;
                    tx_data   <= req_data[{win, 3'b000} +: 8];
                    grant_id  <= win;
                    last      <= win;
                    busy      <= 1'b1;
                    cnt       <= '0;
                    baud_rate <= w_baud;
                    state     <= (w_baud != baud_rate) ? CFG : START;
                end
                CFG: begin
                    cnt   <= (cnt == CW'(GAP_CYCLES - 1)) ? '0 : cnt + 1'b1;
                    state <= (cnt == CW'(GAP_CYCLES - 1)) ? START : CFG;
                end
                START: begin
                    tx_start <= 1'b1;
                    state    <= WAIT;
                end
                WAIT: if (tx_done && !tx_start) begin
                    cnt   <= '0;
                    state <= GAP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    timeout_err <= 1'b1;
                    cnt         <= '0;
                    state       <= GAP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                GAP: if (cnt == CW'(GAP_CYCLES - 1)) begin
                    cnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
